// File: rtl/crypt_exec.sv
// crypt_exec: 8-bit multi-cycle execute unit (XOR/ADD/SUB/ROTL/ROTR/ENC/DEC/NOP) with one-shot register-file writeback.
// Define CRYPT_EXEC_ENCDEC_EN to build the ENC/DEC round datapath; without it opcodes 101/110 complete as NOP.
module crypt_exec #(
   parameter int ROUNDS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] opcode,
   input  logic [7:0] op_a,
   input  logic [7:0] op_b,
   input  logic [3:0] rd_in,
   output logic       busy,
   output logic       done,
   output logic       reg_write,
   output logic [3:0] rd,
   output logic [7:0] write_data
);

   localparam logic [2:0] OP_XOR  = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_ROTL = 3'b011;
   localparam logic [2:0] OP_ROTR = 3'b100;
   localparam logic [2:0] OP_ENC  = 3'b101;
   localparam logic [2:0] OP_DEC  = 3'b110;

   if (ROUNDS < 1 || ROUNDS > 15) begin : g_bad_rounds
      $error("crypt_exec: ROUNDS must be in 1..15");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_WB   = 2'd2
   } state_t;

   state_t     r_state;
   logic [2:0] r_op;
   logic [7:0] r_x;
   logic [3:0] r_cnt;
   logic [3:0] r_rd_cap;
   logic       r_busy;
   logic       r_done;
   logic       r_we;
   logic [3:0] r_rd;
   logic [7:0] r_wd;

   logic       w_quick;
   logic       w_writes;
   logic [7:0] w_res;
   logic [3:0] w_cnt_init;
   logic [7:0] w_step;

   function automatic logic [7:0] rotl1(input logic [7:0] x);
      return {x[6:0], x[7]};
   endfunction

   function automatic logic [7:0] rotr1(input logic [7:0] x);
      return {x[0], x[7:1]};
   endfunction

`ifdef CRYPT_EXEC_ENCDEC_EN
   localparam logic [7:0] ROUNDS_B = 8'(ROUNDS);
   localparam logic [3:0] ROUNDS_C = 4'(ROUNDS);

   logic [7:0] r_k;
   logic [7:0] w_idx;

   // r_cnt counts remaining rounds down from ROUNDS; ENC walks i upward, DEC walks it downward.
   always_comb begin
      w_idx = {4'd0, r_cnt} - 8'd1;
      if (r_op == OP_ENC)
         w_idx = ROUNDS_B - {4'd0, r_cnt};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_k <= 8'd0;
      else if (r_state == S_IDLE && start)
         r_k <= op_b;
   end
`endif

   // Acceptance-time decode: single-cycle ops go straight to WB with their result.
   always_comb begin
      w_quick    = 1'b1;
      w_writes   = 1'b1;
      w_res      = op_a;
      w_cnt_init = {1'b0, op_b[2:0]};
      case (opcode)
         OP_XOR:  w_res = op_a ^ op_b;
         OP_ADD:  w_res = op_a + op_b;
         OP_SUB:  w_res = op_a - op_b;
         OP_ROTL,
         OP_ROTR: w_quick = (op_b[2:0] == 3'd0);
`ifdef CRYPT_EXEC_ENCDEC_EN
         OP_ENC,
         OP_DEC: begin
            w_quick    = 1'b0;
            w_cnt_init = ROUNDS_C;
         end
`else
         OP_ENC,
         OP_DEC:  w_writes = 1'b0;
`endif
         default: w_writes = 1'b0;
      endcase
   end

   always_comb begin
      w_step = r_x;
      case (r_op)
         OP_ROTL: w_step = rotl1(r_x);
         OP_ROTR: w_step = rotr1(r_x);
`ifdef CRYPT_EXEC_ENCDEC_EN
         OP_ENC:  w_step = rotl1(r_x ^ r_k) + w_idx;
         OP_DEC:  w_step = rotr1(r_x - w_idx) ^ r_k;
`endif
         default: w_step = r_x;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_op     <= 3'd0;
         r_x      <= 8'd0;
         r_cnt    <= 4'd0;
         r_rd_cap <= 4'd0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_we     <= 1'b0;
         r_rd     <= 4'd0;
         r_wd     <= 8'd0;
      end else begin
         r_done <= 1'b0;
         r_we   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op     <= opcode;
                  r_x      <= op_a;
                  r_rd_cap <= rd_in;
                  r_cnt    <= w_cnt_init;
                  r_busy   <= 1'b1;
                  if (w_quick) begin
                     r_state <= S_WB;
                     r_done  <= 1'b1;
                     r_we    <= w_writes;
                     r_rd    <= rd_in;
                     r_wd    <= w_res;
                  end else begin
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               r_x   <= w_step;
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_state <= S_WB;
                  r_done  <= 1'b1;
                  r_we    <= 1'b1;
                  r_rd    <= r_rd_cap;
                  r_wd    <= w_step;
               end
            end
            S_WB: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign reg_write  = r_we;
   assign rd         = r_rd;
   assign write_data = r_wd;

endmodule

// File: tb/tb_crypt_exec.sv
// Self-checking bench for crypt_exec: vector table driven through a scoreboard plus
// hand sequences for start-held, output hold and mid-operation reset.
module tb_crypt_exec;

   localparam int TB_ROUNDS = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [2:0] opcode = 3'd0;
   logic [7:0] op_a = 8'd0;
   logic [7:0] op_b = 8'd0;
   logic [3:0] rd_in = 4'd0;
   logic       busy, done, reg_write;
   logic [3:0] rd;
   logic [7:0] write_data;

   crypt_exec #(.ROUNDS(TB_ROUNDS)) dut (
      .clk(clk), .reset(reset), .start(start), .opcode(opcode),
      .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
      .busy(busy), .done(done), .reg_write(reg_write),
      .rd(rd), .write_data(write_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] rdi;
      logic [7:0] exp_wd;
      logic       exp_we;
      bit         chk_wd;
      int         lat;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   total = 0;
   int   bad = 0;

   function automatic vec_t mk(string n, logic [2:0] op, logic [7:0] a, logic [7:0] b,
                               logic [3:0] r, logic [7:0] wd, logic we, bit cw, int lat);
      vec_t v;
      v.name = n; v.op = op; v.a = a; v.b = b; v.rdi = r;
      v.exp_wd = wd; v.exp_we = we; v.chk_wd = cw; v.lat = lat;
      return v;
   endfunction

   function automatic logic [7:0] enc_m(logic [7:0] x, logic [7:0] k);
      logic [7:0] t;
      for (int i = 0; i < TB_ROUNDS; i++) begin
         t = x ^ k;
         x = {t[6:0], t[7]} + 8'(i);
      end
      return x;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_done();
      int   cyc;
      bit   seen;
      vec_t e;
      seen = 0;
      for (cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            break;
         end
      end
      e = exp_q.pop_front();
      if (!seen) begin
         total++; bad++;
         $display("FAIL %s.timeout: got no done expected done within 40 cycles", e.name);
         return;
      end
      chk({e.name, ".lat"}, cyc, e.lat);
      chk({e.name, ".we"}, reg_write, e.exp_we);
      chk({e.name, ".rd"}, rd, e.rdi);
      if (e.chk_wd) chk({e.name, ".wd"}, write_data, e.exp_wd);
      chk({e.name, ".busy_wb"}, busy, 1);
      @(negedge clk);
      chk({e.name, ".done_pulse"}, {done, reg_write}, 2'b00);
      chk({e.name, ".busy_after"}, busy, 0);
   endtask

   // Caller is positioned at a negedge; acceptance happens at the next posedge.
   task automatic issue(vec_t v);
      opcode = v.op; op_a = v.a; op_b = v.b; rd_in = v.rdi; start = 1'b1;
      exp_q.push_back(v);
      @(posedge clk); #1;
      start = 1'b0;
      op_a = 8'($urandom); op_b = 8'($urandom); rd_in = 4'($urandom); opcode = 3'($urandom);
      wait_done();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         ndone;
      int         first_cyc;
      logic [7:0] ra, rk, re;

      vecs.push_back(mk("xor",     3'b000, 8'h41, 8'h20, 4'd5,  8'h61, 1'b1, 1, 1));
      vecs.push_back(mk("add",     3'b001, 8'hF0, 8'h20, 4'd3,  8'h10, 1'b1, 1, 1));
      vecs.push_back(mk("sub",     3'b010, 8'h00, 8'h01, 4'd9,  8'hFF, 1'b1, 1, 1));
      vecs.push_back(mk("add_ff",  3'b001, 8'hFF, 8'hFF, 4'd1,  8'hFE, 1'b1, 1, 1));
      vecs.push_back(mk("nop",     3'b111, 8'h12, 8'h34, 4'd2,  8'h00, 1'b0, 0, 1));
      vecs.push_back(mk("rotl3",   3'b011, 8'h81, 8'h03, 4'd7,  8'h0C, 1'b1, 1, 4));
      vecs.push_back(mk("rotr3",   3'b100, 8'h0C, 8'h03, 4'd1,  8'h81, 1'b1, 1, 4));
      vecs.push_back(mk("rotl0",   3'b011, 8'h5A, 8'h08, 4'd15, 8'h5A, 1'b1, 1, 1));
      vecs.push_back(mk("rotr7",   3'b100, 8'hA5, 8'hFF, 4'd8,  8'h4B, 1'b1, 1, 8));
`ifdef CRYPT_EXEC_ENCDEC_EN
      vecs.push_back(mk("enc",     3'b101, 8'h41, 8'h20, 4'd4,  8'hE2, 1'b1, 1, TB_ROUNDS + 1));
      vecs.push_back(mk("dec",     3'b110, 8'hE2, 8'h20, 4'd6,  8'h41, 1'b1, 1, TB_ROUNDS + 1));
      for (int i = 0; i < 4; i++) begin
         ra = 8'($urandom); rk = 8'($urandom); re = enc_m(ra, rk);
         vecs.push_back(mk("enc_rnd", 3'b101, ra, rk, 4'(i), re, 1'b1, 1, TB_ROUNDS + 1));
         vecs.push_back(mk("dec_rnd", 3'b110, re, rk, 4'(i), ra, 1'b1, 1, TB_ROUNDS + 1));
      end
`else
      vecs.push_back(mk("enc_off", 3'b101, 8'h41, 8'h20, 4'd4,  8'h00, 1'b0, 0, 1));
      vecs.push_back(mk("dec_off", 3'b110, 8'hE2, 8'h20, 4'd6,  8'h00, 1'b0, 0, 1));
`endif

      // Reset state, then release at a negedge so the first table op is accepted on the very next edge.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", {busy, done, reg_write, rd, write_data}, 15'd0);
      reset = 1'b0;

      foreach (vecs[i]) issue(vecs[i]);

      // Outputs hold across idle cycles with wiggling inputs.
      issue(mk("hold_op", 3'b000, 8'h3C, 8'h0F, 4'd6, 8'h33, 1'b1, 1, 1));
      repeat (3) begin
         op_a = 8'($urandom); op_b = 8'($urandom); rd_in = 4'($urandom); opcode = 3'($urandom);
         @(negedge clk);
      end
      chk("hold.wd", write_data, 8'h33);
      chk("hold.rd", rd, 4'd6);
      chk("hold.idle", {busy, done, reg_write}, 3'b000);

      // start held high through a 7-step rotate: one acceptance, one done.
      opcode = 3'b011; op_a = 8'h01; op_b = 8'h07; rd_in = 4'd4; start = 1'b1;
      ndone = 0; first_cyc = 0;
      @(posedge clk);
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (first_cyc == 0) begin
               first_cyc = c;
               chk("held.wd", write_data, 8'h80);
               chk("held.we", reg_write, 1'b1);
            end
            start = 1'b0;
         end
      end
      start = 1'b0;
      chk("held.ndone", ndone, 1);
      chk("held.lat", first_cyc, 8);
      chk("held.busy_end", busy, 0);

      // Reset mid-operation: aborted without a write, then a fresh op runs normally.
`ifdef CRYPT_EXEC_ENCDEC_EN
      opcode = 3'b101; op_a = 8'h41; op_b = 8'h20; rd_in = 4'd11; start = 1'b1;
`else
      opcode = 3'b011; op_a = 8'h41; op_b = 8'h07; rd_in = 4'd11; start = 1'b1;
`endif
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort.busy_pre", busy, 1);
      reset = 1'b1;
      #1;
      chk("abort.outs", {busy, done, reg_write, rd, write_data}, 15'd0);
      ndone = 0;
      repeat (3) begin
         @(negedge clk);
         if (reg_write || done) ndone++;
      end
      reset = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (reg_write || done) ndone++;
      end
      chk("abort.no_write", ndone, 0);
      issue(mk("post_rst", 3'b000, 8'h41, 8'h20, 4'd5, 8'h61, 1'b1, 1, 1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/crypt_exec.md
CRYPT_EXEC -- requirements
Module: crypt_exec

Interface
REQ-001 Parameter ROUNDS, default 4: number of ENC/DEC rounds; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled only while busy=0.
REQ-005 opcode  input  3  000 XOR, 001 ADD, 010 SUB, 011 ROTL, 100 ROTR, 101 ENC, 110 DEC, 111 NOP.
REQ-006 op_a  input  8  first operand, the register-file rs1 read value.
REQ-007 op_b  input  8  second operand or key, the register-file rs2 read value.
REQ-008 rd_in  input  4  destination register index.
REQ-009 busy  output  1  high while an accepted operation is in progress.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 reg_write  output  1  register-file write enable; one-cycle pulse.
REQ-012 rd  output  4  registered destination index, driven to the register-file rd port.
REQ-013 write_data  output  8  operation result, driven to the register-file write_data port.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and WB; busy=1 in RUN and WB.
REQ-015 Acceptance SHALL occur at an edge E0 where state=IDLE and start=1; opcode, op_a, op_b and rd_in are captured, and later input changes are ignored.
REQ-016 start while busy=1 SHALL be ignored and not queued; this includes the WB cycle.
REQ-017 Latency: done SHALL be high for exactly the cycle following edge E0+N, where N is defined per opcode in REQ-018 to REQ-020.
REQ-018 XOR, ADD, SUB, NOP: N=0; the transition is IDLE->WB directly; ADD and SUB wrap modulo 256 with no carry or borrow output.
REQ-019 ROTL and ROTR: c=op_b[2:0], N=c; one 1-bit rotate per RUN cycle; for c=0, IDLE->WB directly and result=op_a.
REQ-020 ENC and DEC: N=ROUNDS, one round per RUN cycle, key k=op_b, 8-bit wrapping arithmetic.
  - ENC round i (i=0..ROUNDS-1): x = rotl1(x^k) + i.
  - DEC round i (i=ROUNDS-1..0): x = rotr1(x - i) ^ k.
REQ-021 DEC SHALL exactly invert ENC for any x, k and ROUNDS.
REQ-022 In WB, done=1 and the FSM returns to IDLE on the next edge.
  - reg_write=1 except for NOP.
  - rd and write_data are valid.
REQ-023 write_data and rd SHALL hold their last value until the next WB.
REQ-024 An opcode 101/110 compiled out (see REQ-028) SHALL behave exactly as NOP.

Reset
REQ-025 While reset is high, state=IDLE and all outputs are 0: busy, done, reg_write, rd, write_data.
REQ-026 Reset asserted mid-operation SHALL abort the operation immediately with no reg_write.
REQ-027 The first acceptance after reset SHALL be possible at the first edge after reset deasserts.

Configuration
REQ-028 Macro CRYPT_EXEC_ENCDEC_EN controls the ENC/DEC datapath.
  - Defined: the ENC/DEC datapath and round counter are compiled in.
  - Undefined: they are compiled out, opcodes 101/110 behave as NOP (done pulse after one cycle, no write), and all other opcodes are unaffected.

Verification
REQ-029 XOR, op_a=0x41, op_b=0x20, rd_in=5 -> one cycle later: done=1, reg_write=1, rd=5, write_data=0x61; next cycle busy=0.
REQ-030 ADD 0xF0+0x20 -> 0x10; SUB 0x00-0x01 -> 0xFF; NOP -> done=1, reg_write=0.
REQ-031 ROTL op_a=0x81, op_b=0x03 -> done in the 4th cycle after acceptance, write_data=0x0C; ROTR 0x0C by 3 -> 0x81; ROTL by 0 -> op_a after 1 cycle.
REQ-032 ROUNDS=4, macro defined: ENC op_a=0x41, k=0x20 -> 0xE2 after 5 cycles; DEC 0xE2, k=0x20 -> 0x41. With the macro undefined: ENC -> done after 1 cycle, no reg_write.
REQ-033 start held high during a ROTL by 7 -> only one acceptance and one done pulse.
REQ-034 Reset pulsed during ENC round 2 -> no reg_write and all outputs 0; a new XOR issued after reset completes normally.
